// File: rtl/featuremap_conv2d_0_linebuf.sv
// rtl/featuremap_conv2d_0_linebuf.sv - two-row line buffer turning a raster pixel stream into 3-row column words
// Optional FMAP_LB_FRAME_DONE_EN adds a registered frame_done pulse after the last pixel of each frame.
module featuremap_conv2d_0_linebuf #(
  parameter int DWIDTH     = 32,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DWIDTH-1:0]     ff_rdata,
  output logic                  ff_rdreq,
  input  logic                  ff_empty,
  output logic [3*DWIDTH-1:0]   ff_wdata,
  output logic                  ff_wrreq,
  input  logic                  ff_full
`ifdef FMAP_LB_FRAME_DONE_EN
  ,output logic                 frame_done
`endif
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DWIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DWIDTH-1:0] lb1 [IMG_WIDTH];

  logic stream;
  logic pop;
  logic col_last;
  logic row_last;

  // FILL/STREAM is implied by the row counter; no separate state register is kept.
  assign stream   = (row >= ROW_TWO);
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  // A full downstream FIFO only blocks pops once pops also produce pushes.
  assign pop      = !reset && !ff_empty && (!stream || !ff_full);
  assign ff_rdreq = pop;
  assign ff_wrreq = pop && stream;
  assign ff_wdata = {lb1[col], lb0[col], ff_rdata};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (pop) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffers carry no reset; every entry is rewritten during FILL before it is read.
  always_ff @(posedge clock) begin
    if (pop) begin
      lb1[col] <= lb0[col];
      lb0[col] <= ff_rdata;
    end
  end

`ifdef FMAP_LB_FRAME_DONE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop && col_last && row_last;
    end
  end
`endif

endmodule
